glb_mu_rd_arbiter: RTL and testbench

- Shares the single matrix-unit read port of the global buffer between two requesters. Requester 0 is the matrix unit's unified port; requester 1 is a second MU-side client such as a weight prefetcher.
- The GLB port uses a TileLink-style A (request) / D (response) channel pair.
- Arbitration on A is round-robin with grant locking. The requester ID is tagged into the source MSB, and D responses are routed back by that tag.
- Per-requester outstanding transactions are tracked, and multi-beat responses are counted so that credits are returned only on the last beat.
- Sits between the MU wrapper and Garnet's mu_tl_* port.

---
 rtl/glb_mu_rd_arbiter_if.sv | 56 +++++
 rtl/glb_mu_rd_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_glb_mu_rd_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/glb_mu_rd_arbiter_if.sv
// ---------------------------------------------------------------------------
// glb_mu_rd_arbiter_if
// Bundles every bus signal of the two-requester GLB matrix-unit read arbiter:
//   req_a_*  : per-requester TileLink A channel (2 lanes, requester i in slice i)
//   req_d_*  : D channel back to the requesters (valid per requester, payload
//              broadcast)
//   glb_a_*  : single A channel towards the global buffer
//   glb_d_*  : single D channel from the global buffer
//   outstanding_cnt / err_unexpected_d : status from the arbiter
// Modports:
//   master : arbiter view (drives glb_a_*, req_a_ready, req_d_*, glb_d_ready,
//            status)
//   slave  : environment view (requesters plus GLB)
// ---------------------------------------------------------------------------
interface glb_mu_rd_arbiter_if;
  logic [1:0]   req_a_valid;
  logic [1:0]   req_a_ready;
  logic [41:0]  req_a_address;
  logic [7:0]   req_a_size;
  logic [11:0]  req_a_source;
  logic [1:0]   req_d_valid;
  logic [1:0]   req_d_ready;
  logic [255:0] req_d_data;
  logic [3:0]   req_d_size;
  logic [5:0]   req_d_source;
  logic [2:0]   req_d_opcode;
  logic         glb_a_valid;
  logic         glb_a_ready;
  logic [20:0]  glb_a_address;
  logic [3:0]   glb_a_size;
  logic [6:0]   glb_a_source;
  logic         glb_d_valid;
  logic         glb_d_ready;
  logic [255:0] glb_d_data;
  logic [3:0]   glb_d_size;
  logic [6:0]   glb_d_source;
  logic [2:0]   glb_d_opcode;
  logic [7:0]   outstanding_cnt;
  logic         err_unexpected_d;

  modport master (
    input  req_a_valid, req_a_address, req_a_size, req_a_source, req_d_ready,
    input  glb_a_ready, glb_d_valid, glb_d_data, glb_d_size, glb_d_source, glb_d_opcode,
    output req_a_ready, req_d_valid, req_d_data, req_d_size, req_d_source, req_d_opcode,
    output glb_a_valid, glb_a_address, glb_a_size, glb_a_source, glb_d_ready,
    output outstanding_cnt, err_unexpected_d
  );

  modport slave (
    output req_a_valid, req_a_address, req_a_size, req_a_source, req_d_ready,
    output glb_a_ready, glb_d_valid, glb_d_data, glb_d_size, glb_d_source, glb_d_opcode,
    input  req_a_ready, req_d_valid, req_d_data, req_d_size, req_d_source, req_d_opcode,
    input  glb_a_valid, glb_a_address, glb_a_size, glb_a_source, glb_d_ready,
    input  outstanding_cnt, err_unexpected_d
  );
endinterface

// File: rtl/glb_mu_rd_arbiter.sv
// ---------------------------------------------------------------------------
// glb_mu_rd_arbiter
// Shares the matrix-unit read port of the global buffer between requester 0
// (MU unified port) and requester 1 (e.g. weight prefetcher).
//   A channel : round-robin with grant lock, zero-latency combinational path,
//               requester ID carried in glb_a_source[6].
//   D channel : routed combinationally by glb_d_source[6]; a shared beat
//               counter finds the last beat of multi-beat responses, and only
//               the last beat returns an outstanding credit.
// Ports:
//   clk_in     : clock
//   reset_in_n : asynchronous active-low reset (also masks handshake outputs)
//   bus        : glb_mu_rd_arbiter_if.master (see interface header)
// ---------------------------------------------------------------------------
module glb_mu_rd_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned BEAT_BYTES_LOG2 = 5,
  parameter int unsigned MAX_BEATS_LOG2  = 3
) (
  input  logic                clk_in,
  input  logic                reset_in_n,
  glb_mu_rd_arbiter_if.master bus
);

  localparam int unsigned BCW         = MAX_BEATS_LOG2 + 1;
  localparam logic [3:0]  MAX_OUT_C   = 4'(MAX_OUTSTANDING);
  localparam logic [3:0]  BEAT_LOG2_C = 4'(BEAT_BYTES_LOG2);
  localparam logic [3:0]  MAX_SHIFT_C = 4'(MAX_BEATS_LOG2);

  // State
  logic [1:0][3:0] cnt_q, cnt_d;
  logic            rr_q, rr_d;
  logic            lock_q, lock_d;
  logic            locked_id_q, locked_id_d;
  logic [BCW-1:0]  beat_cnt_q, beat_cnt_d;
  logic            err_q, err_d;

  // Combinational helpers
  logic [1:0]      elig_s;
  logic            grant_s;
  logic            a_valid_s;
  logic            a_hs_s;
  logic            sel_s;
  logic            d_hs_s;
  logic            last_beat_s;
  logic [3:0]      diff_s;
  logic [3:0]      shift_s;
  logic [BCW-1:0]  beats_s;
  logic [1:0]      inc_s;
  logic [1:0]      dec_s;

  // Eligibility: valid request and a free credit
  always_comb begin
    elig_s = 2'b00;
    for (int i = 0; i < 2; i++) begin
      elig_s[i] = bus.req_a_valid[i] & (cnt_q[i] < MAX_OUT_C);
    end
  end

  // Grant selection; a held offer ignores eligibility and follows only the
  // locked requester's valid, so a protocol violation drops the offer
  always_comb begin
    grant_s   = 1'b0;
    a_valid_s = 1'b0;
    if (lock_q) begin
      grant_s   = locked_id_q;
      a_valid_s = bus.req_a_valid[locked_id_q];
    end else if (elig_s == 2'b11) begin
      grant_s   = rr_q;
      a_valid_s = 1'b1;
    end else if (elig_s[1]) begin
      grant_s   = 1'b1;
      a_valid_s = 1'b1;
    end else if (elig_s[0]) begin
      grant_s   = 1'b0;
      a_valid_s = 1'b1;
    end else begin
      grant_s   = 1'b0;
      a_valid_s = 1'b0;
    end
  end

  // A path: muxed fields of the granted requester, forced idle while in reset
  assign bus.glb_a_valid   = a_valid_s & reset_in_n;
  assign a_hs_s            = bus.glb_a_valid & bus.glb_a_ready;
  assign bus.glb_a_address = grant_s ? bus.req_a_address[41:21] : bus.req_a_address[20:0];
  assign bus.glb_a_size    = grant_s ? bus.req_a_size[7:4] : bus.req_a_size[3:0];
  assign bus.glb_a_source  = {grant_s, (grant_s ? bus.req_a_source[11:6] : bus.req_a_source[5:0])};
  assign bus.req_a_ready   = {a_hs_s & grant_s, a_hs_s & ~grant_s};

  // D path: route by requester tag, payload broadcast
  assign sel_s            = bus.glb_d_source[6];
  assign bus.req_d_valid  = (bus.glb_d_valid & reset_in_n) ? (sel_s ? 2'b10 : 2'b01) : 2'b00;
  assign bus.glb_d_ready  = bus.req_d_ready[sel_s] & reset_in_n;
  assign d_hs_s           = bus.glb_d_valid & bus.glb_d_ready;
  assign bus.req_d_data   = bus.glb_d_data;
  assign bus.req_d_size   = bus.glb_d_size;
  assign bus.req_d_source = bus.glb_d_source[5:0];
  assign bus.req_d_opcode = bus.glb_d_opcode;

  // Beats in the current response: 1 up to one beat of bytes, clamped above
  always_comb begin
    diff_s  = 4'd0;
    shift_s = 4'd0;
    if (bus.glb_d_size > BEAT_LOG2_C) begin
      diff_s = bus.glb_d_size - BEAT_LOG2_C;
      if (diff_s > MAX_SHIFT_C) begin
        shift_s = MAX_SHIFT_C;
      end else begin
        shift_s = diff_s;
      end
    end else begin
      diff_s  = 4'd0;
      shift_s = 4'd0;
    end
    beats_s = BCW'(1) << shift_s;
  end

  // Beat counter: zero means the next beat opens a new response
  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    last_beat_s = 1'b0;
    if (d_hs_s) begin
      if (beat_cnt_q == BCW'(0)) begin
        if (beats_s == BCW'(1)) begin
          last_beat_s = 1'b1;
        end else begin
          beat_cnt_d = beats_s - BCW'(1);
        end
      end else begin
        beat_cnt_d  = beat_cnt_q - BCW'(1);
        last_beat_s = (beat_cnt_q == BCW'(1));
      end
    end else begin
      beat_cnt_d = beat_cnt_q;
    end
  end

  // Lock holds an unaccepted offer; round-robin pointer moves past the winner
  always_comb begin
    lock_d      = 1'b0;
    locked_id_d = locked_id_q;
    rr_d        = rr_q;
    if (bus.glb_a_valid & ~bus.glb_a_ready) begin
      lock_d      = 1'b1;
      locked_id_d = grant_s;
    end else begin
      lock_d = 1'b0;
    end
    if (a_hs_s) begin
      rr_d = ~grant_s;
    end else begin
      rr_d = rr_q;
    end
  end

  assign inc_s = {a_hs_s & grant_s, a_hs_s & ~grant_s};
  assign dec_s = {last_beat_s & sel_s, last_beat_s & ~sel_s};

  // Outstanding counters; an unexpected last beat saturates and sets the error
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    for (int i = 0; i < 2; i++) begin
      if (dec_s[i] && (cnt_q[i] == 4'd0)) begin
        err_d = 1'b1;
      end
      if (inc_s[i] && !dec_s[i]) begin
        cnt_d[i] = cnt_q[i] + 4'd1;
      end else if (dec_s[i] && !inc_s[i] && (cnt_q[i] != 4'd0)) begin
        cnt_d[i] = cnt_q[i] - 4'd1;
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // State registers
  always_ff @(posedge clk_in or negedge reset_in_n) begin
    if (!reset_in_n) begin
      cnt_q       <= '0;
      rr_q        <= 1'b0;
      lock_q      <= 1'b0;
      locked_id_q <= 1'b0;
      beat_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      lock_q      <= lock_d;
      locked_id_q <= locked_id_d;
      beat_cnt_q  <= beat_cnt_d;
      err_q       <= err_d;
    end
  end

  assign bus.outstanding_cnt  = cnt_q;
  assign bus.err_unexpected_d = err_q;

endmodule

// File: tb/tb_glb_mu_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_glb_mu_rd_arbiter
// Directed bench: a cycle-by-cycle vector table (arbitration, lock, D routing)
// followed by hand-written sequences for multi-beat responses, the credit
// limit, simultaneous A/D events, unexpected responses and mid-burst reset.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_glb_mu_rd_arbiter;

  localparam logic [20:0] ADDR0 = 21'h01234;
  localparam logic [20:0] ADDR1 = 21'h1ABCD;
  localparam logic [5:0]  SRC0  = 6'h0A;
  localparam logic [5:0]  SRC1  = 6'h15;
  localparam int          NV    = 17;

  typedef struct {
    logic [1:0] a_valid;
    logic       a_ready;
    logic       d_valid;
    logic [6:0] d_src;
    logic [3:0] d_size;
    logic [1:0] d_ready;
    logic       e_a_valid;
    logic       e_grant;
    logic [1:0] e_a_ready;
    logic [1:0] e_d_valid;
    logic       e_d_ready;
    logic [3:0] e_cnt0;
    logic [3:0] e_cnt1;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  vec_t vecs [NV];

  glb_mu_rd_arbiter_if bus ();

  glb_mu_rd_arbiter dut (
    .clk_in     (clk),
    .reset_in_n (rst_n),
    .bus        (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(
    input logic [1:0] a_valid, input logic a_ready, input logic d_valid,
    input logic [6:0] d_src, input logic [3:0] d_size, input logic [1:0] d_ready,
    input logic e_a_valid, input logic e_grant, input logic [1:0] e_a_ready,
    input logic [1:0] e_d_valid, input logic e_d_ready,
    input logic [3:0] e_cnt0, input logic [3:0] e_cnt1);
    vec_t v;
    v.a_valid = a_valid;   v.a_ready = a_ready;     v.d_valid = d_valid;
    v.d_src = d_src;       v.d_size = d_size;       v.d_ready = d_ready;
    v.e_a_valid = e_a_valid; v.e_grant = e_grant;   v.e_a_ready = e_a_ready;
    v.e_d_valid = e_d_valid; v.e_d_ready = e_d_ready;
    v.e_cnt0 = e_cnt0;     v.e_cnt1 = e_cnt1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] a_valid, input logic a_ready, input logic d_valid,
                       input logic [6:0] d_src, input logic [3:0] d_size, input logic [1:0] d_ready);
    bus.req_a_valid  = a_valid;
    bus.glb_a_ready  = a_ready;
    bus.glb_d_valid  = d_valid;
    bus.glb_d_source = d_src;
    bus.glb_d_size   = d_size;
    bus.req_d_ready  = d_ready;
  endtask

  // One cycle: change inputs on the falling edge, settle, then caller checks
  task automatic apply(input logic [1:0] a_valid, input logic a_ready, input logic d_valid,
                       input logic [6:0] d_src, input logic [3:0] d_size, input logic [1:0] d_ready);
    @(negedge clk);
    drive(a_valid, a_ready, d_valid, d_src, d_size, d_ready);
    #1;
  endtask

  task automatic idle();
    apply(2'b00, 1'b0, 1'b0, 7'h00, 4'h5, 2'b00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(2'b00, 1'b0, 1'b0, 7'h00, 4'h5, 2'b00);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    bus.req_a_address = {ADDR1, ADDR0};
    bus.req_a_size    = {4'h5, 4'h5};
    bus.req_a_source  = {SRC1, SRC0};
    bus.glb_d_data    = {8{32'hA5A5_0001}};
    bus.glb_d_opcode  = 3'd1;

    // Reset with all inputs active: handshake outputs must stay low
    rst_n = 1'b0;
    drive(2'b11, 1'b1, 1'b1, 7'h40, 4'h5, 2'b11);
    #3;
    check("rst glb_a_valid", 32'(bus.glb_a_valid), 32'd0);
    check("rst req_a_ready", 32'(bus.req_a_ready), 32'd0);
    check("rst req_d_valid", 32'(bus.req_d_valid), 32'd0);
    check("rst glb_d_ready", 32'(bus.glb_d_ready), 32'd0);
    check("rst outstanding_cnt", 32'(bus.outstanding_cnt), 32'd0);
    check("rst err", 32'(bus.err_unexpected_d), 32'd0);
    do_reset();

    // a_valid a_rdy d_val d_src  d_size d_rdy | a_val grant a_rdy d_val d_rdy cnt0 cnt1
    vecs[0]  = mk(2'b11, 1'b1, 1'b0, 7'h00, 4'h5, 2'b00, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 4'd0, 4'd0);
    vecs[1]  = mk(2'b11, 1'b1, 1'b0, 7'h00, 4'h5, 2'b00, 1'b1, 1'b1, 2'b10, 2'b00, 1'b0, 4'd1, 4'd0);
    vecs[2]  = mk(2'b11, 1'b1, 1'b0, 7'h00, 4'h5, 2'b00, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 4'd1, 4'd1);
    vecs[3]  = mk(2'b11, 1'b1, 1'b0, 7'h00, 4'h5, 2'b00, 1'b1, 1'b1, 2'b10, 2'b00, 1'b0, 4'd2, 4'd1);
    vecs[4]  = mk(2'b00, 1'b1, 1'b0, 7'h00, 4'h5, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'd2, 4'd2);
    vecs[5]  = mk(2'b01, 1'b1, 1'b0, 7'h00, 4'h5, 2'b00, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 4'd2, 4'd2);
    // lock on req0 while rr points at req1
    vecs[6]  = mk(2'b01, 1'b0, 1'b0, 7'h00, 4'h5, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 4'd3, 4'd2);
    vecs[7]  = mk(2'b11, 1'b0, 1'b0, 7'h00, 4'h5, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 4'd3, 4'd2);
    vecs[8]  = mk(2'b11, 1'b1, 1'b0, 7'h00, 4'h5, 2'b00, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 4'd3, 4'd2);
    vecs[9]  = mk(2'b11, 1'b1, 1'b0, 7'h00, 4'h5, 2'b00, 1'b1, 1'b1, 2'b10, 2'b00, 1'b0, 4'd4, 4'd2);
    // lock on req1, then req1 drops valid: offer withdrawn, lock released
    vecs[10] = mk(2'b10, 1'b0, 1'b0, 7'h00, 4'h5, 2'b00, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 4'd4, 4'd3);
    vecs[11] = mk(2'b01, 1'b1, 1'b0, 7'h00, 4'h5, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'd4, 4'd3);
    vecs[12] = mk(2'b01, 1'b1, 1'b0, 7'h00, 4'h5, 2'b00, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 4'd4, 4'd3);
    // D routing, single-beat responses
    vecs[13] = mk(2'b00, 1'b0, 1'b1, 7'h45, 4'h5, 2'b10, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, 4'd5, 4'd3);
    vecs[14] = mk(2'b00, 1'b0, 1'b1, 7'h03, 4'h4, 2'b10, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 4'd5, 4'd2);
    vecs[15] = mk(2'b00, 1'b0, 1'b1, 7'h03, 4'h4, 2'b01, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1, 4'd5, 4'd2);
    vecs[16] = mk(2'b00, 1'b0, 1'b0, 7'h00, 4'h5, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'd4, 4'd2);

    for (int v = 0; v < NV; v++) begin
      apply(vecs[v].a_valid, vecs[v].a_ready, vecs[v].d_valid,
            vecs[v].d_src, vecs[v].d_size, vecs[v].d_ready);
      check($sformatf("v%0d glb_a_valid", v), 32'(bus.glb_a_valid), 32'(vecs[v].e_a_valid));
      if (vecs[v].e_a_valid) begin
        check($sformatf("v%0d grant", v), 32'(bus.glb_a_source[6]), 32'(vecs[v].e_grant));
        check($sformatf("v%0d glb_a_address", v), 32'(bus.glb_a_address),
              32'(vecs[v].e_grant ? ADDR1 : ADDR0));
        check($sformatf("v%0d glb_a_source", v), 32'(bus.glb_a_source[5:0]),
              32'(vecs[v].e_grant ? SRC1 : SRC0));
      end
      check($sformatf("v%0d req_a_ready", v), 32'(bus.req_a_ready), 32'(vecs[v].e_a_ready));
      check($sformatf("v%0d req_d_valid", v), 32'(bus.req_d_valid), 32'(vecs[v].e_d_valid));
      check($sformatf("v%0d glb_d_ready", v), 32'(bus.glb_d_ready), 32'(vecs[v].e_d_ready));
      check($sformatf("v%0d cnt0", v), 32'(bus.outstanding_cnt[3:0]), 32'(vecs[v].e_cnt0));
      check($sformatf("v%0d cnt1", v), 32'(bus.outstanding_cnt[7:4]), 32'(vecs[v].e_cnt1));
    end

    // Multi-beat: req1 size 7 -> 4 beats; credit only on beat 4
    do_reset();
    bus.req_a_size = {4'h7, 4'h5};
    apply(2'b10, 1'b1, 1'b0, 7'h00, 4'h5, 2'b00);
    check("mb a_ready", 32'(bus.req_a_ready), 32'(2'b10));
    check("mb glb_a_size", 32'(bus.glb_a_size), 32'd7);
    for (int k = 0; k < 4; k++) begin
      bus.glb_d_data = {8{32'hC0DE_0000 + 32'(k)}};
      apply(2'b00, 1'b0, 1'b1, 7'h45, 4'h7, 2'b11);
      check($sformatf("mb%0d req_d_valid", k), 32'(bus.req_d_valid), 32'(2'b10));
      check($sformatf("mb%0d req_d_source", k), 32'(bus.req_d_source), 32'h05);
      check($sformatf("mb%0d req_d_data", k), bus.req_d_data[255:224], 32'hC0DE_0000 + 32'(k));
      check($sformatf("mb%0d cnt1", k), 32'(bus.outstanding_cnt[7:4]), 32'd1);
    end
    check("mb req_d_opcode", 32'(bus.req_d_opcode), 32'd1);
    idle();
    check("mb cnt1 after", 32'(bus.outstanding_cnt[7:4]), 32'd0);
    check("mb err", 32'(bus.err_unexpected_d), 32'd0);

    // Credit limit and simultaneous A/D on req0
    do_reset();
    bus.req_a_size = {4'h5, 4'h5};
    for (int k = 0; k < 8; k++) begin
      apply(2'b01, 1'b1, 1'b0, 7'h00, 4'h5, 2'b00);
      check($sformatf("cl%0d a_ready", k), 32'(bus.req_a_ready), 32'(2'b01));
    end
    apply(2'b11, 1'b1, 1'b0, 7'h00, 4'h5, 2'b00);
    check("cl full a_ready", 32'(bus.req_a_ready), 32'(2'b10));
    check("cl full cnt0", 32'(bus.outstanding_cnt[3:0]), 32'd8);
    apply(2'b01, 1'b1, 1'b1, 7'h00, 4'h5, 2'b01);
    check("cl credit a_ready", 32'(bus.req_a_ready), 32'(2'b00));
    check("cl credit glb_a_valid", 32'(bus.glb_a_valid), 32'd0);
    apply(2'b01, 1'b1, 1'b1, 7'h00, 4'h5, 2'b01);
    check("sim a_ready", 32'(bus.req_a_ready), 32'(2'b01));
    check("sim cnt0 before", 32'(bus.outstanding_cnt[3:0]), 32'd7);
    idle();
    check("sim cnt0 after", 32'(bus.outstanding_cnt[3:0]), 32'd7);
    check("sim cnt1", 32'(bus.outstanding_cnt[7:4]), 32'd1);
    check("sim err", 32'(bus.err_unexpected_d), 32'd0);

    // Unexpected response for req1 with nothing outstanding
    do_reset();
    apply(2'b00, 1'b0, 1'b1, 7'h40, 4'h5, 2'b10);
    check("err req_d_valid", 32'(bus.req_d_valid), 32'(2'b10));
    idle();
    check("err flag", 32'(bus.err_unexpected_d), 32'd1);
    check("err cnt1 sat", 32'(bus.outstanding_cnt[7:4]), 32'd0);
    idle();
    check("err sticky", 32'(bus.err_unexpected_d), 32'd1);

    // Asynchronous reset in the middle of a 4-beat response
    do_reset();
    apply(2'b01, 1'b1, 1'b0, 7'h00, 4'h5, 2'b00);
    apply(2'b00, 1'b0, 1'b1, 7'h00, 4'h7, 2'b01);
    @(negedge clk);
    drive(2'b11, 1'b1, 1'b1, 7'h00, 4'h7, 2'b01);
    #1;
    rst_n = 1'b0;
    #1;
    check("ar glb_a_valid", 32'(bus.glb_a_valid), 32'd0);
    check("ar req_a_ready", 32'(bus.req_a_ready), 32'd0);
    check("ar req_d_valid", 32'(bus.req_d_valid), 32'd0);
    check("ar glb_d_ready", 32'(bus.glb_d_ready), 32'd0);
    check("ar outstanding_cnt", 32'(bus.outstanding_cnt), 32'd0);
    @(negedge clk);
    drive(2'b00, 1'b0, 1'b0, 7'h00, 4'h5, 2'b00);
    rst_n = 1'b1;
    // Beat counter must be clear: a single-beat response is a last beat again
    apply(2'b01, 1'b1, 1'b0, 7'h00, 4'h5, 2'b00);
    apply(2'b00, 1'b0, 1'b1, 7'h00, 4'h5, 2'b01);
    check("ar post glb_d_ready", 32'(bus.glb_d_ready), 32'd1);
    check("ar post cnt0 before", 32'(bus.outstanding_cnt[3:0]), 32'd1);
    idle();
    check("ar post cnt0 after", 32'(bus.outstanding_cnt[3:0]), 32'd0);
    check("ar post err", 32'(bus.err_unexpected_d), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
